// File: rtl/wg_pkg.sv
// Shared constants and helpers for the Winograd F(3,3) stream engine.
// Matrices use Toom-Cook points {0,1,-1,2,inf}; the filter transform is pre-scaled by 6 to stay integral.
package wg_pkg;

  localparam int BT [5][5] = '{'{2, -1, -2,  1, 0},
                               '{0, -2, -1,  1, 0},
                               '{0,  2, -3,  1, 0},
                               '{0, -1,  0,  1, 0},
                               '{0,  2, -1, -2, 1}};

  localparam int G6 [5][3] = '{'{ 3,  0,  0},
                               '{-3, -3, -3},
                               '{-1,  1, -1},
                               '{ 1,  2,  4},
                               '{ 0,  0,  6}};

  localparam int AT [3][5] = '{'{1, 1,  1, 1, 0},
                               '{0, 1, -1, 2, 0},
                               '{0, 1,  1, 4, 1}};

  function automatic int aw_of(input int w);
    return 2 * w + 12;
  endfunction

  // Newton iteration x <- x*(2-3x) doubles the number of correct bits each step.
  function automatic logic [63:0] inv3(input int aw);
    logic [63:0] x;
    x = 64'd3;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - 64'd3 * x);
    return (aw >= 64) ? x : (x & ((64'd1 << aw) - 64'd1));
  endfunction

  function automatic logic [63:0] sat_reduce(input logic signed [63:0] y, input int ow, input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sat && (y > hi)) return hi;
    if (sat && (y < lo)) return lo;
    return y;
  endfunction

endpackage

// File: rtl/wg_filter_xform.sv
// Filter transform U = 6*G*g, registered on an accepted load.
// Latency: U valid the edge after g_load & g_ready; load_busy covers the load cycle and the next.
// Backpressure: g_ready only while the datapath is empty, so in-flight tiles never see a new U.
module wg_filter_xform
  import wg_pkg::*;
#(
  parameter int W  = 10,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            g_load,
  input  logic [3*W-1:0]  g_in,
  input  logic            pipe_busy,
  output logic            g_ready,
  output logic            load_busy,
  output logic [5*AW-1:0] u
);

  logic                 load_q;
  logic                 load_acc;
  logic signed [W-1:0]  g_s   [3];
  logic signed [AW-1:0] u_nxt [5];

  assign g_ready   = ~pipe_busy & ~load_q;
  assign load_acc  = g_load & g_ready;
  assign load_busy = load_q | load_acc;

  always_comb begin
    for (int k = 0; k < 3; k++) g_s[k] = g_in[(2-k)*W +: W];
    for (int r = 0; r < 5; r++) begin
      u_nxt[r] = '0;
      for (int c = 0; c < 3; c++) u_nxt[r] = u_nxt[r] + AW'(G6[r][c]) * AW'(g_s[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= 1'b0;
      u      <= '0;
    end else begin
      load_q <= load_acc;
      if (load_acc) begin
        for (int r = 0; r < 5; r++) u[(4-r)*AW +: AW] <= u_nxt[r];
      end
    end
  end

endmodule

// File: rtl/wg_f33_stream.sv
// Streaming Winograd F(3,3) correlation: 5-sample tile in, 3 outputs out, runtime-loadable filter.
// Latency: 4 clocks accept-to-out_valid, 1 tile/clk throughput.
// Backpressure: whole pipeline freezes while out_valid & !out_ready; in_ready also drops during a filter load.
module wg_f33_stream
  import wg_pkg::*;
#(
  parameter int W   = 10,
  parameter int OW  = 10,
  parameter int SAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            g_load,
  input  logic [3*W-1:0]  g_in,
  output logic            g_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5*W-1:0]  D,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3*OW-1:0] Z
);

  localparam int            AW   = aw_of(W);
  localparam logic [AW-1:0] INV3 = AW'(inv3(AW));

  logic                 en;
  logic                 accept;
  logic                 pipe_busy;
  logic                 load_busy;
  logic                 v1, v2, v3;
  logic [5*AW-1:0]      u;
  logic signed [W-1:0]  d_s   [5];
  logic signed [AW-1:0] v_nxt [5];
  logic signed [AW-1:0] v_q   [5];
  logic signed [AW-1:0] m_q   [5];
  logic signed [AW-1:0] p_nxt [3];
  logic signed [AW-1:0] p_q   [3];
  logic signed [AW-1:0] y     [3];
  logic [3*OW-1:0]      z_nxt;

  assign en        = ~(out_valid & ~out_ready);
  assign pipe_busy = v1 | v2 | v3 | out_valid;
  assign in_ready  = en & ~load_busy;
  assign accept    = in_valid & in_ready;

  wg_filter_xform #(.W(W), .AW(AW)) u_xform (
    .clk       (clk),
    .rst       (rst),
    .g_load    (g_load),
    .g_in      (g_in),
    .pipe_busy (pipe_busy),
    .g_ready   (g_ready),
    .load_busy (load_busy),
    .u         (u)
  );

  always_comb begin
    for (int c = 0; c < 5; c++) d_s[c] = D[(4-c)*W +: W];
    for (int r = 0; r < 5; r++) begin
      v_nxt[r] = '0;
      for (int c = 0; c < 5; c++) v_nxt[r] = v_nxt[r] + AW'(BT[r][c]) * AW'(d_s[c]);
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      p_nxt[r] = '0;
      for (int c = 0; c < 5; c++) p_nxt[r] = p_nxt[r] + AW'(AT[r][c]) * m_q[c];
    end
  end

  // P is exactly 6*y: halve, then multiply by 3^-1 mod 2^AW to finish the division.
  always_comb begin
    z_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      y[i] = (p_q[i] >>> 1) * $signed(INV3);
      z_nxt[(2-i)*OW +: OW] = OW'(sat_reduce(64'(y[i]), OW, SAT != 0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      Z         <= '0;
    end else if (en) begin
      v1        <= accept;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) Z <= z_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int r = 0; r < 5; r++) begin
        v_q[r] <= v_nxt[r];
        m_q[r] <= v_q[r] * $signed(u[(4-r)*AW +: AW]);
      end
      for (int r = 0; r < 3; r++) p_q[r] <= p_nxt[r];
    end
  end

endmodule

// File: tb/tb_wg_f33_stream.sv
// Scoreboard bench for wg_f33_stream: saturating and wrapping instances share stimulus,
// expectations are queued at tile acceptance and popped by a monitor on each output handshake.
module tb_wg_f33_stream;

  localparam int W  = 10;
  localparam int OW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            g_load;
  logic [3*W-1:0]  g_in;
  logic            in_valid;
  logic [5*W-1:0]  D;
  logic            out_ready;
  logic            g_ready_s, in_ready_s, out_valid_s;
  logic            g_ready_w, in_ready_w, out_valid_w;
  logic [3*OW-1:0] z_s, z_w;
  logic [29:0]     qs[$];
  logic [29:0]     qw[$];
  logic [29:0]     zh;
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              last_acc = 0;
  int              cur_g [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wg_f33_stream #(.W(W), .OW(OW), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .g_load(g_load), .g_in(g_in), .g_ready(g_ready_s),
    .in_valid(in_valid), .in_ready(in_ready_s), .D(D),
    .out_valid(out_valid_s), .out_ready(out_ready), .Z(z_s)
  );

  wg_f33_stream #(.W(W), .OW(OW), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .g_load(g_load), .g_in(g_in), .g_ready(g_ready_w),
    .in_valid(in_valid), .in_ready(in_ready_w), .D(D),
    .out_valid(out_valid_w), .out_ready(out_ready), .Z(z_w)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired, got no event expected one", nm);
  endtask

  function automatic logic [29:0] pk(input int a, input int b, input int c);
    return {a[9:0], b[9:0], c[9:0]};
  endfunction

  // Direct correlation with the filter currently loaded, then clamp or wrap.
  function automatic logic [29:0] model(input int d0, d1, d2, d3, d4, input bit sat);
    int d [5];
    int yv [3];
    d = '{d0, d1, d2, d3, d4};
    for (int i = 0; i < 3; i++) begin
      yv[i] = d[i]*cur_g[0] + d[i+1]*cur_g[1] + d[i+2]*cur_g[2];
      if (sat && yv[i] > 511) yv[i] = 511;
      if (sat && yv[i] < -512) yv[i] = -512;
    end
    return pk(yv[0], yv[1], yv[2]);
  endfunction

  task automatic send(input int d0, d1, d2, d3, d4, input logic [29:0] es, input logic [29:0] ew);
    bit ok;
    ok = 1'b0;
    D = {W'(d0), W'(d1), W'(d2), W'(d3), W'(d4)};
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready_s;
    end
    if (!ok) timeout("tile_accept");
    else begin
      qs.push_back(es);
      qw.push_back(ew);
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input int d0, d1, d2, d3, d4);
    send(d0, d1, d2, d3, d4, model(d0, d1, d2, d3, d4, 1'b1), model(d0, d1, d2, d3, d4, 1'b0));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int g0, g1, g2);
    bit ok;
    ok = 1'b0;
    g_in = {W'(g0), W'(g1), W'(g2)};
    g_load = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = g_ready_s;
    end
    if (!ok) timeout("filter_load");
    @(posedge clk);
    #1;
    g_load = 1'b0;
    cur_g = '{g0, g1, g2};
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid_s && out_ready) begin
      if (qs.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL z_sat_unexpected: got %0h expected no output", z_s);
      end else check("z_sat", 32'(z_s), 32'(qs.pop_front()));
    end
    if (!rst && out_valid_w && out_ready) begin
      if (qw.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL z_wrap_unexpected: got %0h expected no output", z_w);
      end else check("z_wrap", 32'(z_w), 32'(qw.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    rst = 1'b1; g_load = 1'b0; g_in = '0; in_valid = 1'b0; D = '0; out_ready = 1'b1;
    cur_g = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_s), 0);
    check("rst_z_sat", 32'(z_s), 0);
    check("rst_z_wrap", 32'(z_w), 0);
    check("rst_g_ready", 32'(g_ready_s), 1);
    check("rst_in_ready", 32'(in_ready_s), 1);

    // 1: basic result and exact 4-cycle latency
    load(1, 2, 3);
    send(1, 2, 3, 4, 5, pk(14, 20, 26), pk(14, 20, 26));
    in_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = out_valid_s;
    end
    check("latency", cyc - last_acc, 4);
    idle(3);

    // 2: load and tile presented together; load wins, tile follows with new filter
    g_in = {W'(-1), W'(0), W'(2)};
    g_load = 1'b1;
    D = {W'(2), W'(-10), W'(3), W'(4), W'(-13)};
    in_valid = 1'b1;
    @(negedge clk);
    check("load_g_ready", 32'(g_ready_s), 1);
    check("load_wins_in_ready", 32'(in_ready_s), 0);
    @(posedge clk);
    #1 g_load = 1'b0;
    cur_g = '{-1, 0, 2};
    @(negedge clk);
    check("load_busy_in_ready", 32'(in_ready_s), 0);
    send(2, -10, 3, 4, -13, pk(4, 18, -29), pk(4, 18, -29));
    send(1, 2, 3, 4, 5, pk(5, 6, 7), pk(5, 6, 7));
    idle(8);

    // 3: saturation vs wrap at both extremes
    load(511, 511, 511);
    send(511, 511, 511, 511, 511, pk(511, 511, 511), pk(3, 3, 3));
    send(-511, -511, -511, -511, -511, pk(-512, -512, -512), pk(-3, -3, -3));
    idle(8);

    // 4: 8-tile stream with a 3-cycle consumer stall
    load(1, 2, 3);
    fork
      begin
        for (int k = 0; k < 8; k++) send_m(k, k + 1, -k, 2*k - 7, 3);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2 out_ready = 1'b0;
        zh = z_s;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_out_valid", 32'(out_valid_s), 1);
          check("stall_in_ready", 32'(in_ready_s), 0);
          check("stall_z_hold", 32'(z_s), 32'(zh));
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    idle(10);

    // 5: load requested while tiles in flight must wait for drain
    send_m(3, -2, 7, 1, 0);
    send_m(-4, 5, 6, -8, 9);
    send_m(10, 0, -3, 2, 2);
    in_valid = 1'b0;
    g_in = {W'(-1), W'(0), W'(2)};
    g_load = 1'b1;
    @(negedge clk);
    check("busy_g_ready", 32'(g_ready_s), 0);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (g_ready_s) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) timeout("drain_g_ready");
    check("drained_before_load", qs.size(), 0);
    check("load_cycle_in_ready", 32'(in_ready_s), 0);
    @(posedge clk);
    #1 g_load = 1'b0;
    cur_g = '{-1, 0, 2};
    send_m(3, 1, 4, 1, 5);
    idle(8);

    // 6: reset with tiles in flight
    load(1, 2, 3);
    send_m(1, 1, 1, 1, 1);
    send_m(2, 2, 2, 2, 2);
    send_m(3, 3, 3, 3, 3);
    in_valid = 1'b0;
    rst = 1'b1;
    qs.delete();
    qw.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cur_g = '{0, 0, 0};
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid_s), 0);
    check("midrst_z_sat", 32'(z_s), 0);
    check("midrst_z_wrap", 32'(z_w), 0);
    check("midrst_g_ready", 32'(g_ready_s), 1);
    idle(8);
    send(1, 2, 3, 4, 5, pk(0, 0, 0), pk(0, 0, 0));
    idle(10);

    check("sat_queue_empty", qs.size(), 0);
    check("wrap_queue_empty", qw.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
